mux_share_arbiter: RTL and testbench
====================================

# mux_share_arbiter

Round-robin burst arbiter that shares the 4-bit 2:1 datapath mux between two requesters, A and B.

- Each requester presents a valid/ready stream.
- The block drives the mux select from the arbitration result and registers the muxed beat into a one-entry output stage.
- It sits in front of any shared 4-bit operand/result path in the processor datapath where two sources contend for one consumer.

## Interface
Parameters:
- DATA_W, 4, width of the data path; matches the mux width.
- MAX_BURST, 4, max consecutive beats granted to one requester while the other waits; legal range ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  requester A has a beat.
- a_data  in  DATA_W  requester A beat.
- a_ready  out  1  A beat accepted this cycle (a_valid && a_ready).
- b_valid  in  1  requester B has a beat.
- b_data  in  DATA_W  requester B beat.
- b_ready  out  1  B beat accepted this cycle.
- sel  out  1  mux select; 0 = A, 1 = B.
- out_valid  out  1  output register holds a beat.
- out_data  out  DATA_W  output beat.
- out_ready  in  1  consumer takes the beat.

## Operation
State:
- owner: 1 bit, last granted requester.
- cnt: $clog2(MAX_BURST+1) bits, consecutive beats granted to owner, saturating at MAX_BURST.
- Output register: out_valid, out_data.

Load enable:
- ld = !out_valid || out_ready.

Winner (combinational):
- Only A valid: winner = A.
- Only B valid: winner = B.
- Both valid, owner's cnt < MAX_BURST: winner = owner.
- Both valid, cnt == MAX_BURST: winner = the other requester.
- Neither valid: no winner.

Outputs and updates:
- sel = winner when any requester is valid, otherwise owner. The mux output is sel ? b_data : a_data.
- a_ready = ld && a_valid && winner==A. b_ready is symmetric. At most one ready per cycle.
- On a transfer (ld && a requester valid):
  - out_data ← mux output, out_valid ← 1.
  - If winner == owner: cnt ← min(cnt+1, MAX_BURST).
  - Otherwise: owner ← winner, cnt ← 1.
- On ld with no requester valid: out_valid ← 0 (an accepted beat drains); owner and cnt hold.
- When !ld: all state holds. out_data is stable while out_valid && !out_ready.
- MAX_BURST = 1 gives strict alternation under continuous contention.
- A lone requester is never starved or throttled. It streams at 1 beat/cycle and cnt saturates.

Reset (asynchronous, immediate, including mid-burst or with out_valid high):
- out_valid = 0, out_data = 0.
- owner = A, cnt = 0. The first tie therefore goes to A.
- sel = 0.
- a_ready and b_ready follow the combinational rules (ld = 1).
- Any held beat is dropped.

## Timing
- Latency: a beat accepted in cycle N appears on out_data/out_valid in cycle N+1.
- Throughput: 1 beat/cycle when out_ready is held high.
- a_ready, b_ready and sel are combinational from a_valid, b_valid, out_ready and state.
  - Requesters must not make valid depend on ready.
  - Once asserted, a requester's valid and data must hold until its ready is seen.
- Backpressure: with out_valid=1 and out_ready=0, both readys are 0 and no arbitration state changes.
- A simultaneous drain and refill (out_valid=1, out_ready=1, requester valid) is a transfer in the same cycle with no bubble.
- A grant switch costs no idle cycle.

## Test plan
- Reset check: assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0 and sel=0 immediately. After release, a tie goes to A first.
- Single requester: A streams 0x1..0x8 with out_ready=1 → out_data = 0x1..0x8 on consecutive cycles, one cycle behind. b_ready is never asserted.
- Contention, MAX_BURST=4: A sends 0xA repeatedly and B sends 0xB repeatedly, both continuous, out_ready=1 → output pattern is A×4, B×4, A×4, … with no bubbles.
- Backpressure: out_ready=0 for 3 cycles while both requesters are valid → out_data holds its value, readys stay 0, owner and cnt are unchanged. Release → the pending beat drains and the next is loaded in the same cycle.
- Handover: A valid for 2 beats then drops while B stays valid → B is granted the next cycle, owner=B, cnt=1, no idle cycle.
- MAX_BURST=1 with both valid → outputs strictly alternate A, B, A, B starting with A.

Source files
------------

// File: rtl/mux_share_arbiter.sv
// Round-robin burst arbiter sharing one DATA_W-bit 2:1 mux between requesters A and B,
// with a one-entry registered output stage.
module mux_share_arbiter #(
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic            OWN_A   = 1'b0;
    localparam logic            OWN_B   = 1'b1;

    logic              owner_q;
    logic              owner_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;

    logic              ld_s;
    logic              any_valid_s;
    logic              winner_s;
    logic [DATA_W-1:0] mux_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val >= CNT_MAX) begin
            sat_inc = CNT_MAX;
        end else begin
            sat_inc = val + CNT_ONE;
        end
    endfunction

    // Arbitration: winner defaults to owner, so sel falls back to owner when idle.
    always_comb begin
        winner_s    = owner_q;
        any_valid_s = a_valid | b_valid;
        ld_s        = ~out_valid_q | out_ready;
        if (a_valid && !b_valid) begin
            winner_s = OWN_A;
        end else if (!a_valid && b_valid) begin
            winner_s = OWN_B;
        end else if (a_valid && b_valid) begin
            if (cnt_q < CNT_MAX) begin
                winner_s = owner_q;
            end else begin
                winner_s = ~owner_q;
            end
        end else begin
            winner_s = owner_q;
        end
    end

    // Mux select and per-requester handshakes.
    always_comb begin
        sel     = winner_s;
        mux_s   = winner_s ? b_data : a_data;
        a_ready = ld_s & a_valid & (winner_s == OWN_A);
        b_ready = ld_s & b_valid & (winner_s == OWN_B);
    end

    // Next-state: load on transfer, drain when idle, hold under backpressure.
    always_comb begin
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (ld_s && any_valid_s) begin
            out_data_d  = mux_s;
            out_valid_d = 1'b1;
            if (winner_s == owner_q) begin
                cnt_d = sat_inc(cnt_q);
            end else begin
                owner_d = winner_s;
                cnt_d   = CNT_ONE;
            end
        end else if (ld_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset drops any held beat and hands the first tie to A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= OWN_A;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Scoreboard bench for mux_share_arbiter: a MAX_BURST=4 instance and a MAX_BURST=1 instance.
module tb_mux_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid, out_ready;
    logic [3:0] a_data, b_data;
    logic       a_ready, b_ready, sel, out_valid;
    logic [3:0] out_data;

    logic       p_a_valid, p_b_valid, p_out_ready;
    logic [3:0] p_a_data, p_b_data;
    logic       p_a_ready, p_b_ready, p_sel, p_out_valid;
    logic [3:0] p_out_data;

    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp1_q[$];
    logic [3:0] e0, e1;

    always #5 clk = ~clk;

    mux_share_arbiter #(.DATA_W(4), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    mux_share_arbiter #(.DATA_W(4), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(p_a_valid), .a_data(p_a_data), .a_ready(p_a_ready),
        .b_valid(p_b_valid), .b_data(p_b_data), .b_ready(p_b_ready),
        .sel(p_sel), .out_valid(p_out_valid), .out_data(p_out_data), .out_ready(p_out_ready)
    );

    // Scoreboard for the MAX_BURST=4 instance: every consumed beat must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb0_extra: got %0h required no beat", out_data);
            end else begin
                e0 = exp_q.pop_front();
                if (out_data !== e0) begin
                    bad++;
                    $display("FAIL sb0_data: got %0h required %0h", out_data, e0);
                end
            end
        end
    end

    // Scoreboard for the MAX_BURST=1 instance.
    always @(negedge clk) begin
        if (rst_n && p_out_valid && p_out_ready) begin
            total++;
            if (exp1_q.size() == 0) begin
                bad++;
                $display("FAIL sb1_extra: got %0h required no beat", p_out_data);
            end else begin
                e1 = exp1_q.pop_front();
                if (p_out_data !== e1) begin
                    bad++;
                    $display("FAIL sb1_data: got %0h required %0h", p_out_data, e1);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0; a_data = 4'h0; b_data = 4'h0;
        p_a_valid = 1'b0; p_b_valid = 1'b0; p_out_ready = 1'b0; p_a_data = 4'h0; p_b_data = 4'h0;
        rst_n = 1'b0;
        #2;
        exp_q.delete();
        exp1_q.delete();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b1; a_data = 4'h7; b_valid = 1'b0; b_data = 4'h0; out_ready = 1'b0;
        p_a_valid = 1'b0; p_b_valid = 1'b0; p_out_ready = 1'b0; p_a_data = 4'h0; p_b_data = 4'h0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", out_valid); end
        total++; if (out_data !== 4'h0) begin bad++; $display("FAIL rst_data: got %0h required 0", out_data); end
        total++; if (sel !== 1'b0) begin bad++; $display("FAIL rst_sel: got %b required 0", sel); end
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rst_a_ready: got %b required 1", a_ready); end
        a_valid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 1'b1;
        a_valid   = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a_data = 4'(i);
            exp_q.push_back(4'(i));
            @(negedge clk);
            next_cycle();
        end
        out_ready = 1'b0;
        a_data    = 4'h4;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_data !== 4'h3) begin bad++; $display("FAIL mid_hold: got %b/%0h required 1/3", out_valid, out_data); end
        next_cycle();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b required 0", out_valid); end
        total++; if (out_data !== 4'h0) begin bad++; $display("FAIL mid_rst_data: got %0h required 0", out_data); end
        total++; if (sel !== 1'b0) begin bad++; $display("FAIL mid_rst_sel: got %b required 0", sel); end
        a_valid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        a_valid = 1'b1; a_data = 4'h1;
        b_valid = 1'b1; b_data = 4'h2;
        exp_q.push_back(4'h1);
        @(negedge clk);
        total++; if (a_ready !== 1'b1 || b_ready !== 1'b0 || sel !== 1'b0) begin
            bad++; $display("FAIL tie_after_rst: got a=%b b=%b sel=%b required a=1 b=0 sel=0", a_ready, b_ready, sel);
        end
        next_cycle();
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        next_cycle();
    endtask

    task automatic test_single();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_valid = 1'b1; a_data = 4'(i);
            exp_q.push_back(4'(i));
            @(negedge clk);
            total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
                bad++; $display("FAIL single_ready[%0d]: got a=%b b=%b required a=1 b=0", i, a_ready, b_ready);
            end
            if (i > 1) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_bubble[%0d]: got %b required 1", i, out_valid); end
            end
            next_cycle();
        end
        a_valid = 1'b0;
        @(negedge clk);
        total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin bad++; $display("FAIL single_idle_ready: got a=%b b=%b required 0 0", a_ready, b_ready); end
        next_cycle();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b required 0", out_valid); end
        next_cycle();
    endtask

    task automatic test_contention();
        logic exp_b;
        apply_reset();
        out_ready = 1'b1;
        a_valid = 1'b1; a_data = 4'hA;
        b_valid = 1'b1; b_data = 4'hB;
        for (int i = 0; i < 16; i++) begin
            exp_b = ((i / 4) % 2) == 1;
            exp_q.push_back(exp_b ? 4'hB : 4'hA);
            @(negedge clk);
            total++; if (a_ready !== ~exp_b || b_ready !== exp_b || sel !== exp_b) begin
                bad++; $display("FAIL contend[%0d]: got a=%b b=%b sel=%b required sel=%b", i, a_ready, b_ready, sel, exp_b);
            end
            if (i > 0) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL contend_bubble[%0d]: got %b required 1", i, out_valid); end
            end
            next_cycle();
        end
    endtask

    // Continues from test_contention: B just finished a full burst of MAX_BURST beats.
    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got a=%b b=%b required 0 0", i, a_ready, b_ready); end
            total++; if (out_valid !== 1'b1 || out_data !== 4'hB) begin bad++; $display("FAIL bp_hold[%0d]: got %b/%0h required 1/b", i, out_valid, out_data); end
            total++; if (dut.owner_q !== 1'b1 || dut.cnt_q !== 3'd4) begin
                bad++; $display("FAIL bp_state[%0d]: got owner=%b cnt=%0d required owner=1 cnt=4", i, dut.owner_q, dut.cnt_q);
            end
            next_cycle();
        end
        out_ready = 1'b1;
        exp_q.push_back(4'hA);
        @(negedge clk);
        total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++; $display("FAIL bp_release: got a=%b b=%b required 1 0", a_ready, b_ready); end
        next_cycle();
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        next_cycle();
    endtask

    task automatic test_handover();
        apply_reset();
        out_ready = 1'b1;
        b_valid = 1'b1; b_data = 4'hC;
        a_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_data = 4'(3 + i);
            exp_q.push_back(4'(3 + i));
            @(negedge clk);
            total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++; $display("FAIL ho_a[%0d]: got a=%b b=%b required 1 0", i, a_ready, b_ready); end
            next_cycle();
        end
        a_valid = 1'b0;
        exp_q.push_back(4'hC);
        @(negedge clk);
        total++; if (b_ready !== 1'b1 || sel !== 1'b1) begin bad++; $display("FAIL ho_b_grant: got b=%b sel=%b required 1 1", b_ready, sel); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ho_bubble: got %b required 1", out_valid); end
        next_cycle();
        b_valid = 1'b0;
        @(negedge clk);
        total++; if (dut.owner_q !== 1'b1 || dut.cnt_q !== 3'd1) begin
            bad++; $display("FAIL ho_state: got owner=%b cnt=%0d required owner=1 cnt=1", dut.owner_q, dut.cnt_q);
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ho_out: got %b required 1", out_valid); end
        next_cycle();
        @(negedge clk);
        next_cycle();
    endtask

    task automatic test_alternate();
        logic exp_b;
        apply_reset();
        p_out_ready = 1'b1;
        p_a_valid = 1'b1; p_a_data = 4'h5;
        p_b_valid = 1'b1; p_b_data = 4'h6;
        for (int i = 0; i < 8; i++) begin
            exp_b = (i % 2) == 1;
            exp1_q.push_back(exp_b ? 4'h6 : 4'h5);
            @(negedge clk);
            total++; if (p_a_ready !== ~exp_b || p_b_ready !== exp_b) begin
                bad++; $display("FAIL alt[%0d]: got a=%b b=%b required b=%b", i, p_a_ready, p_b_ready, exp_b);
            end
            next_cycle();
        end
        p_a_valid = 1'b0; p_b_valid = 1'b0;
        @(negedge clk);
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_single();
        test_contention();
        test_backpressure();
        test_handover();
        test_alternate();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb0_left: got %0d beats required 0", exp_q.size()); end
        total++; if (exp1_q.size() != 0) begin bad++; $display("FAIL sb1_left: got %0d beats required 0", exp1_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
